// File: rtl/p2s_s2p_link_param.sv
// LANES x WIDTH serializer/deserializer: K-flag framed symbols out, idle-aligned word reassembly in.
// TX accepts one word per F=WIDTH+1 cycles via OUT_READY; loopback word returns F+1 cycles after accept; RX never backpressures.
module p2s_s2p_link_param #(
   parameter int               LANES    = 4,
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] IDLE_SYM = 8'hBC,
   parameter int               SYNC_CNT = 4
) (
   input  logic                   IN_CLK,
   input  logic                   IN_RESET,
   input  logic [LANES*WIDTH-1:0] IN_DATA,
   input  logic                   IN_VALID,
   output logic                   OUT_READY,
   input  logic                   IN_ENB_TX,
   input  logic                   IN_ENB_RX,
   input  logic                   IN_MSB_FIRST,
   output logic [LANES-1:0]       OUT_SER,
   input  logic [LANES-1:0]       IN_SER,
   output logic [LANES*WIDTH-1:0] OUT_DATA,
   output logic                   OUT_VALID,
   output logic                   OUT_ALIGNED,
   output logic                   OUT_ERR
);

   localparam int F  = WIDTH + 1;
   localparam int CW = (F > 1) ? $clog2(F) : 1;
   localparam int MW = $clog2(SYNC_CNT + 1);
   localparam logic [CW-1:0] LAST      = CW'(F - 1);
   localparam logic [MW-1:0] SYNC_LAST = MW'(SYNC_CNT - 1);

   typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

   function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      for (int b = 0; b < WIDTH; b++) r[b] = v[WIDTH-1-b];
      return r;
   endfunction

   // Frame bit F-1 goes out first, so the payload is stored pre-ordered for the wire.
   function automatic logic [F-1:0] mk_frame(input logic k, input logic [WIDTH-1:0] pay,
                                             input logic msb);
      return {k, msb ? pay : bit_rev(pay)};
   endfunction

   // ---------------- TX ----------------
   logic [CW-1:0]             tx_cnt_q, tx_cnt_d;
   logic [LANES-1:0][F-1:0]   tx_sh_q, tx_sh_d;
   logic                      tx_xfer;

   assign OUT_READY = IN_ENB_TX && (tx_cnt_q == LAST);
   assign tx_xfer   = IN_VALID && OUT_READY;

   always_comb begin
      tx_cnt_d = tx_cnt_q;
      tx_sh_d  = tx_sh_q;
      if (!IN_ENB_TX) begin
         tx_cnt_d = LAST;
         tx_sh_d  = '0;
      end else if (tx_cnt_q == LAST) begin
         tx_cnt_d = '0;
         for (int i = 0; i < LANES; i++)
            tx_sh_d[i] = mk_frame(!tx_xfer, tx_xfer ? IN_DATA[i*WIDTH +: WIDTH] : IDLE_SYM,
                                  IN_MSB_FIRST);
      end else begin
         tx_cnt_d = tx_cnt_q + 1'b1;
         for (int i = 0; i < LANES; i++)
            tx_sh_d[i] = {tx_sh_q[i][F-2:0], 1'b0};
      end
   end

   always_comb begin
      OUT_SER = '0;
      for (int i = 0; i < LANES; i++) OUT_SER[i] = tx_sh_q[i][F-1];
   end

   // ---------------- RX ----------------
   state_t                    st_q, st_d;
   logic [LANES-1:0][F-1:0]   rx_win_q, rx_win_d;
   logic [CW-1:0]             rx_cnt_q, rx_cnt_d;
   logic [MW-1:0]             match_q, match_d;
   logic [LANES*WIDTH-1:0]    data_q, data_d, rx_pay;
   logic                      vld_q, vld_d, err_q, err_d, aln_q, aln_d;
   logic                      all_idle, all_data, boundary;

   always_comb begin
      rx_pay   = '0;
      all_idle = 1'b1;
      all_data = 1'b1;
      for (int i = 0; i < LANES; i++) begin
         rx_pay[i*WIDTH +: WIDTH] = IN_MSB_FIRST ? rx_win_q[i][WIDTH-1:0]
                                                 : bit_rev(rx_win_q[i][WIDTH-1:0]);
         if (!rx_win_q[i][F-1]) all_idle = 1'b0;
         if (rx_win_q[i][F-1])  all_data = 1'b0;
         if ((IN_MSB_FIRST ? rx_win_q[i][WIDTH-1:0] : bit_rev(rx_win_q[i][WIDTH-1:0]))
             != IDLE_SYM)
            all_idle = 1'b0;
      end
   end

   assign boundary = (rx_cnt_q == LAST);

   always_comb begin
      st_d     = st_q;
      rx_win_d = rx_win_q;
      rx_cnt_d = rx_cnt_q;
      match_d  = match_q;
      data_d   = data_q;
      vld_d    = 1'b0;
      err_d    = 1'b0;
      if (!IN_ENB_RX) begin
         st_d     = HUNT;
         rx_win_d = '0;
         rx_cnt_d = '0;
         match_d  = '0;
      end else begin
         for (int i = 0; i < LANES; i++)
            rx_win_d[i] = {rx_win_q[i][F-2:0], IN_SER[i]};
         rx_cnt_d = boundary ? '0 : rx_cnt_q + 1'b1;
         case (st_q)
            HUNT: begin
               // Any all-idle window pins the frame phase; the count restarts here.
               if (all_idle) begin
                  st_d     = CHECK;
                  rx_cnt_d = '0;
                  match_d  = MW'(1);
               end
            end
            CHECK: begin
               if (boundary) begin
                  if (all_idle) begin
                     match_d = match_q + 1'b1;
                     if (match_q == SYNC_LAST) st_d = LOCKED;
                  end else begin
                     st_d = HUNT;
                  end
               end
            end
            LOCKED: begin
               if (boundary) begin
                  if (all_data) begin
                     data_d = rx_pay;
                     vld_d  = 1'b1;
                  end else if (!all_idle) begin
                     err_d = 1'b1;
                     st_d  = HUNT;
                  end
               end
            end
            default: st_d = HUNT;
         endcase
      end
      aln_d = (st_d == LOCKED);
   end

   always_ff @(posedge IN_CLK) begin
      if (!IN_RESET) begin
         tx_cnt_q <= LAST;
         tx_sh_q  <= '0;
         st_q     <= HUNT;
         rx_win_q <= '0;
         rx_cnt_q <= '0;
         match_q  <= '0;
         data_q   <= '0;
         vld_q    <= 1'b0;
         err_q    <= 1'b0;
         aln_q    <= 1'b0;
      end else begin
         tx_cnt_q <= tx_cnt_d;
         tx_sh_q  <= tx_sh_d;
         st_q     <= st_d;
         rx_win_q <= rx_win_d;
         rx_cnt_q <= rx_cnt_d;
         match_q  <= match_d;
         data_q   <= data_d;
         vld_q    <= vld_d;
         err_q    <= err_d;
         aln_q    <= aln_d;
      end
   end

   assign OUT_DATA    = data_q;
   assign OUT_VALID   = vld_q;
   assign OUT_ERR     = err_q;
   assign OUT_ALIGNED = aln_q;

endmodule

// File: tb/tb_p2s_s2p_link_param.sv
// Loopback bench for p2s_s2p_link_param: vector table plus scoreboard of expected words and lane-0 frames.
`timescale 1ns/1ps
module tb_p2s_s2p_link_param;

   localparam int LANES = 4;
   localparam int WIDTH = 8;
   localparam int F     = WIDTH + 1;

   typedef struct {
      logic [31:0] din;
      logic        msb;
      logic [31:0] exp_word;
      logic [8:0]  exp_ser0;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n, enb_tx, enb_rx, msb, vin;
   logic [31:0] din;
   logic [3:0]  flip;
   logic        ready, vout, aligned, err;
   logic [3:0]  ser_o, ser_i;
   logic [31:0] dout;

   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          err_cnt = 0;
   logic [31:0] exp_q[$];
   logic [8:0]  ser_q[$];
   int          due_q[$];
   int          cap_n = 0;
   logic [8:0]  cap_bits = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign ser_i = ser_o ^ flip;

   p2s_s2p_link_param #(.LANES(LANES), .WIDTH(WIDTH), .IDLE_SYM(8'hBC), .SYNC_CNT(4)) dut (
      .IN_CLK(clk), .IN_RESET(rst_n), .IN_DATA(din), .IN_VALID(vin), .OUT_READY(ready),
      .IN_ENB_TX(enb_tx), .IN_ENB_RX(enb_rx), .IN_MSB_FIRST(msb), .OUT_SER(ser_o),
      .IN_SER(ser_i), .OUT_DATA(dout), .OUT_VALID(vout), .OUT_ALIGNED(aligned), .OUT_ERR(err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
      end
   endtask

   task automatic fail_now(input string msg);
      n_cmp++;
      n_bad++;
      $display("FAIL %s", msg);
   endtask

   // Output-side scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         due_q.delete();
         cap_n = 0;
      end else begin
         if (err) err_cnt++;
         if (vout) begin
            if (exp_q.size() == 0)
               fail_now($sformatf("unexpected_valid: got word 0x%0h, want no output", dout));
            else begin
               check("rx_word", dout, exp_q.pop_front());
               if (due_q.size() > 0) check("rx_latency_cycle", cyc, due_q.pop_front());
            end
         end
         if (cap_n > 0) begin
            cap_bits = {cap_bits[7:0], ser_o[0]};
            cap_n--;
            if (cap_n == 0 && ser_q.size() > 0) check("ser0_frame", cap_bits, ser_q.pop_front());
         end
         if (vin && ready) begin
            due_q.push_back(cyc + F + 2);
            cap_n = F;
         end
      end
   end

   task automatic wait_ready(input string name);
      int n = 0;
      while (!ready && n < 40) begin @(posedge clk); #1; n++; end
      if (!ready) fail_now($sformatf("%s: OUT_READY never rose, want within 40 cycles", name));
   endtask

   task automatic send(input vec_t v, output int acc);
      exp_q.push_back(v.exp_word);
      ser_q.push_back(v.exp_ser0);
      din = v.din;
      vin = 1'b1;
      wait_ready("send_ready");
      acc = cyc + 1;
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int n = 0;
      vin = 1'b0;
      while (exp_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
      if (exp_q.size() != 0)
         fail_now($sformatf("drain: %0d words still pending, want 0", exp_q.size()));
      @(posedge clk); #1;
   endtask

   task automatic wait_lock(input int start, input int want, input string name);
      int n = 0;
      do begin @(negedge clk); n++; end while (!aligned && n < 200);
      if (aligned) check(name, cyc - start, want);
      else fail_now($sformatf("%s: OUT_ALIGNED never rose, want rise after %0d cycles", name, want));
   endtask

   initial begin
      vec_t tbl[7];
      int   r, t, e, n;
      int   acc[4];
      tbl[0] = '{32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 9'b0_1111_0111};
      tbl[1] = '{32'h01020304, 1'b0, 32'h01020304, 9'b0_0010_0000};
      tbl[2] = '{32'h11223344, 1'b0, 32'h11223344, 9'b0_0010_0010};
      tbl[3] = '{32'hA5A55A5A, 1'b0, 32'hA5A55A5A, 9'b0_0101_1010};
      tbl[4] = '{32'hBCBCBCBC, 1'b0, 32'hBCBCBCBC, 9'b0_0011_1101};
      tbl[5] = '{32'hBCBCBC80, 1'b1, 32'hBCBCBC80, 9'b0_1000_0000};
      tbl[6] = '{32'h12345678, 1'b1, 32'h12345678, 9'b0_0111_1000};

      rst_n = 1'b0; enb_tx = 1'b0; enb_rx = 1'b0; msb = 1'b0;
      vin = 1'b0; din = '0; flip = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ser", ser_o, 0);
      check("rst_data", dout, 0);
      check("rst_valid", vout, 0);
      check("rst_aligned", aligned, 0);
      check("rst_err", err, 0);
      check("rst_ready", ready, 0);

      // Lock-up from reset: 4 idle boundaries, rise 38 cycles after release.
      @(posedge clk); #1;
      rst_n = 1'b1; enb_tx = 1'b1; enb_rx = 1'b1; r = cyc;
      wait_lock(r, 38, "lock_initial");
      check("lock_no_err", err_cnt, 0);

      // Single word, LSB first.
      send(tbl[0], t);
      drain();

      // Streaming with IN_VALID held, including an idle-pattern payload as data.
      for (int i = 1; i <= 4; i++) send(tbl[i], acc[i-1]);
      for (int i = 1; i < 4; i++) check("ready_period", acc[i] - acc[i-1], F);
      drain();

      // Bit order change while disabled, then relock.
      enb_tx = 1'b0; enb_rx = 1'b0;
      repeat (3) @(posedge clk); #1;
      check("dis_aligned", aligned, 0);
      check("dis_ser", ser_o, 0);
      msb = tbl[5].msb;
      enb_tx = 1'b1; enb_rx = 1'b1; r = cyc;
      wait_lock(r, 38, "lock_msb_first");
      send(tbl[5], t);
      send(tbl[6], t);
      drain();

      // Framing error: corrupt lane 2's K bit of one idle frame.
      wait_ready("err_ready");
      @(posedge clk); #1;
      t = cyc; flip = 4'b0100;
      @(posedge clk); #1;
      flip = 4'b0000;
      n = 0;
      do begin @(negedge clk); n++; end while (!err && n < 30);
      if (err) begin
         check("err_cycle", cyc - t, 10);
         check("err_aligned_low", aligned, 0);
         e = cyc;
         wait_lock(e, 36, "relock_after_err");
      end else begin
         fail_now("err_pulse: OUT_ERR never rose, want pulse 10 cycles after corruption");
      end
      check("err_count", err_cnt, 1);

      // Reset halfway through a data frame: no word, reset outputs, fresh lock.
      @(posedge clk); #1;
      din = 32'h5555AAAA; vin = 1'b1;
      wait_ready("rst_word_ready");
      @(posedge clk); #1;
      vin = 1'b0;
      repeat (4) @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("rst2_ser", ser_o, 0);
      check("rst2_data", dout, 0);
      check("rst2_valid", vout, 0);
      check("rst2_aligned", aligned, 0);
      check("rst2_err", err, 0);
      @(posedge clk); #1;
      rst_n = 1'b1; r = cyc;
      wait_lock(r, 38, "lock_after_reset");
      repeat (15) @(posedge clk);
      #1;
      check("queues_empty", exp_q.size() + ser_q.size(), 0);
      check("final_err_count", err_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/p2s_s2p_link_param.md
Name: p2s_s2p_link_param

Overview:
- Parametrised single-clock serializer/deserializer link, successor to the fixed 4x8-bit, two-clock p2s/s2p conditioning pair.
- TX serializes LANES parallel words of WIDTH bits, one bit per lane per clock, into framed symbols. Each frame is 1 control flag (K) plus WIDTH payload bits.
- RX aligns to idle frames with a hunt/check/lock FSM and reassembles words. It delivers each word with a valid pulse and flags framing errors.
- TX output and RX input are separate ports; the bench or top level wires OUT_SER to IN_SER.

Parameters:
- LANES, 4, number of serial lanes.
- WIDTH, 8, payload bits per lane per frame. Frame length F = WIDTH+1.
- IDLE_SYM, 8'hBC, WIDTH-bit payload sent with K=1 when no data is pending.
- SYNC_CNT, 4, consecutive all-lane idle frames required to declare lock (>=2).

Ports:
- IN_CLK  in  1  single clock, rising edge.
- IN_RESET  in  1  synchronous, active-low reset.
- IN_DATA  in  LANES*WIDTH  TX word; lane i = bits [i*WIDTH +: WIDTH].
- IN_VALID  in  1  TX word available.
- OUT_READY  out  1  TX accepts IN_DATA this cycle (combinational).
- IN_ENB_TX  in  1  TX enable.
- IN_ENB_RX  in  1  RX enable.
- IN_MSB_FIRST  in  1  payload bit order for TX and RX: 1 = MSB first. Change only while both enables are low.
- OUT_SER  out  LANES  serial TX lanes (registered).
- IN_SER  in  LANES  serial RX lanes.
- OUT_DATA  out  LANES*WIDTH  received word (registered).
- OUT_VALID  out  1  one-cycle pulse, OUT_DATA valid.
- OUT_ALIGNED  out  1  RX in LOCKED.
- OUT_ERR  out  1  one-cycle pulse on framing error.

Behaviour:
- Reset (IN_RESET=0 at an edge):
  - OUT_SER=0, TX frame counter=F-1, TX shift registers=0.
  - RX windows=0, RX counter=0, FSM=HUNT.
  - OUT_DATA=0, OUT_VALID=0, OUT_ALIGNED=0, OUT_ERR=0.
  - Reset overrides every other input, including mid-frame.
- TX:
  - OUT_READY = IN_ENB_TX && tx_cnt==F-1. A word transfers at an edge where IN_VALID && OUT_READY.
  - At every edge with tx_cnt==F-1 and TX enabled, each lane loads a frame and tx_cnt becomes 0.
    - Transfer: frame = {K=0, payload}.
    - Otherwise: frame = {K=1, IDLE_SYM}.
  - Otherwise tx_cnt increments and the frame shifts one bit.
  - OUT_SER carries K in the cycle after the load, then payload per IN_MSB_FIRST.
  - Throughput: one word per F cycles.
  - IN_ENB_TX=0: OUT_SER=0, tx_cnt forced to F-1, frame in flight discarded.
- RX:
  - Each enabled cycle, every lane shifts IN_SER into an F-bit window.
  - A lane window is "idle" when it holds K=1 followed by IDLE_SYM in the configured order. It is "data" when K=0.
  - HUNT: the first cycle all windows are idle marks a frame boundary. rx_cnt restarts, match=1, go to CHECK.
  - Boundaries then occur every F enabled cycles.
  - CHECK, at each boundary:
    - All lanes idle: match++. Reaching SYNC_CNT goes to LOCKED.
    - Anything else: back to HUNT, no OUT_ERR.
  - LOCKED, at each boundary:
    - All lanes idle: no output.
    - All lanes data: OUT_DATA = payloads, OUT_VALID=1 next cycle.
    - Mixed K, or K=1 with a payload other than IDLE_SYM: OUT_ERR=1 next cycle, FSM to HUNT, OUT_ALIGNED=0.
  - OUT_ALIGNED is registered and high exactly while in LOCKED.
  - Payloads equal to IDLE_SYM with K=0 are data.
  - IN_ENB_RX=0: FSM forced to HUNT, windows cleared, OUT_VALID/OUT_ERR/OUT_ALIGNED=0. OUT_DATA holds.
- Latency, with OUT_SER wired to IN_SER and RX locked: OUT_VALID asserts F+1 = WIDTH+2 cycles after the accepting edge.
- Simultaneous TX/RX activity is independent; no backpressure from RX.

Test Plan:
1. Lock-up: reset 2 cycles, both enables=1, IN_VALID=0, loopback. OUT_ALIGNED stays 0 through the first 3 idle boundaries. It rises 1 cycle after the 4th boundary, about cycle 37 for defaults. OUT_ERR never asserts.
2. Single word: after lock, IN_DATA=32'hDEADBEEF, IN_MSB_FIRST=0, IN_VALID held until OUT_READY. OUT_VALID pulses once, 10 cycles after the accept edge, with OUT_DATA=32'hDEADBEEF.
3. Streaming: IN_VALID held high with 0x01020304, 0x11223344, 0xA5A55A5A. OUT_READY pulses every 9 cycles. Three OUT_VALID pulses 9 cycles apart return the words in order.
4. Bit order and idle collision: IN_MSB_FIRST=1 (set while disabled, then relock), IN_DATA=32'hBCBCBC80. OUT_SER[0] shows 0,1,0,0,0,0,0,0,0. Received word is 32'hBCBCBC80 as data, not idle.
5. Framing error: while locked, bench inverts IN_SER[2] during one K-bit cycle of an idle frame. OUT_ERR pulses once and OUT_ALIGNED drops. Relock follows after 4 clean idle frames.
6. Reset mid-frame: assert IN_RESET=0 halfway through a data frame. On the next edge all outputs take their reset values. No OUT_VALID for that word. Relock proceeds as in scenario 1.
